// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and baud-rate helper for the configurable UART.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   // Rounded clocks-per-oversample-tick.
   function automatic int baud_div(input int clk_freq, input int baud);
      return (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Circular FIFO with an N-lane read window and saturating multi-pop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int N     = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic [$clog2(N+1)-1:0]     pop,
   output logic [N-1:0][W-1:0]        data,
   output logic [$clog2(N+1)-1:0]     can_pop,
   output logic                       overrun
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_sum_w = c_ptr_w + 1;
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam int c_pop_w = $clog2(N + 1);

   logic [W-1:0]       r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_head;
   logic [c_ptr_w-1:0] r_tail;
   logic [c_cnt_w-1:0] r_count;

   logic [c_pop_w-1:0] w_pop_eff;
   logic [c_sum_w-1:0] w_head_sum;
   logic               w_full;
   logic               w_push_ok;

   always_comb begin
      can_pop    = (int'(r_count) > N) ? c_pop_w'(N) : c_pop_w'(r_count);
      w_pop_eff  = (pop > can_pop) ? can_pop : pop;
      w_full     = (int'(r_count) == DEPTH);
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      w_push_ok  = push && (!w_full || (w_pop_eff != '0));
      overrun    = push && w_full && (w_pop_eff == '0);
      w_head_sum = {1'b0, r_head} + c_sum_w'(w_pop_eff);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else begin
         if (w_push_ok) begin
            r_mem[r_tail] <= push_data;
            r_tail        <= (r_tail == c_ptr_w'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
         end
         r_head  <= (w_head_sum >= c_sum_w'(DEPTH)) ? c_ptr_w'(w_head_sum - c_sum_w'(DEPTH))
                                                    : c_ptr_w'(w_head_sum);
         r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_eff);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [c_sum_w-1:0] w_sum;
      logic [c_ptr_w-1:0] w_idx;
      assign w_sum   = {1'b0, r_head} + c_sum_w'(i);
      assign w_idx   = (w_sum >= c_sum_w'(DEPTH)) ? c_ptr_w'(w_sum - c_sum_w'(DEPTH))
                                                  : c_ptr_w'(w_sum);
      assign data[i] = (c_pop_w'(i) < can_pop) ? r_mem[w_idx] : '0;
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Brief    : Configurable UART receiver, 16x oversampled, majority-voted bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUDRATE  = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4,
   parameter int N         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [N-1:0][7:0]        data,
   output logic [$clog2(N+1)-1:0]   can_pop,
   input  logic [$clog2(N+1)-1:0]   pop,
   input  logic                     err_clr,
   output logic                     parity_err,
   output logic                     frame_err,
   output logic                     overrun
);

   localparam int      c_div    = baud_div(CLK_FREQ, BAUDRATE);
   localparam int      c_div_w  = (c_div > 1) ? $clog2(c_div) : 1;
   localparam int      c_os_w   = $clog2(OVERSAMPLE);
   localparam parity_e c_parity = (PARITY == 1) ? PAR_ODD :
                                  (PARITY == 2) ? PAR_EVEN : PAR_NONE;
   localparam logic [c_os_w-1:0] c_s7 = c_os_w'(OVERSAMPLE / 2 - 1);
   localparam logic [c_os_w-1:0] c_s8 = c_os_w'(OVERSAMPLE / 2);
   localparam logic [c_os_w-1:0] c_s9 = c_os_w'(OVERSAMPLE / 2 + 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_sync3;
   logic [c_div_w-1:0] r_div_cnt;
   logic [c_os_w-1:0]  r_sample_cnt;
   logic               r_s7;
   logic               r_s8;
   rx_state_e          r_state;
   logic [7:0]         r_shift;
   logic [2:0]         r_bit_idx;
   logic               r_stop_idx;
   logic               r_par_bad;
   logic               r_push;
   logic               r_parity_err;
   logic               r_frame_err;
   logic               r_overrun;

   logic               w_tick;
   logic               w_start;
   logic               w_mid;
   logic               w_bit;
   logic               w_par_exp;
   logic               w_fifo_ovr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_tick    = (r_div_cnt == c_div_w'(c_div - 1));
   assign w_start   = (r_state == ST_IDLE) && r_sync3 && !r_sync2;
   assign w_mid     = w_tick && (r_sample_cnt == c_s9);
   assign w_bit     = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   assign w_par_exp = (c_parity == PAR_ODD) ? ~(^r_shift) : ^r_shift;

   // Divider and sample counter restart on the start edge so that every
   // later bit is sampled around its centre without accumulated phase error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt    <= '0;
         r_sample_cnt <= '0;
         r_s7         <= 1'b0;
         r_s8         <= 1'b0;
      end else if (w_start) begin
         r_div_cnt    <= '0;
         r_sample_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt    <= '0;
         r_sample_cnt <= r_sample_cnt + 1'b1;
         if (r_sample_cnt == c_s7) r_s7 <= r_sync2;
         if (r_sample_cnt == c_s8) r_s8 <= r_sync2;
      end else begin
         r_div_cnt    <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_par_bad    <= 1'b0;
         r_push       <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_push <= 1'b0;
         if (err_clr) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_START;
                  r_shift    <= '0;
                  r_bit_idx  <= '0;
                  r_stop_idx <= 1'b0;
                  r_par_bad  <= 1'b0;
               end
            end
            ST_START: begin
               if (w_mid) r_state <= w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (w_mid) begin
                  r_shift[r_bit_idx] <= w_bit;
                  if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                     r_state <= (c_parity != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_mid) begin
                  r_par_bad <= (w_bit != w_par_exp);
                  r_state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_mid) begin
                  if (!w_bit) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_IDLE;
                  end else if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                     // Back in IDLE at mid-stop so a following start edge is seen.
                     if (r_par_bad) r_parity_err <= 1'b1;
                     else           r_push       <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (r_sync2) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)             r_overrun <= 1'b0;
      else if (w_fifo_ovr) r_overrun <= 1'b1;
      else if (err_clr)    r_overrun <= 1'b0;
   end

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .N     (N),
      .W     (8)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (r_push),
      .push_data (r_shift),
      .pop       (pop),
      .data      (data),
      .can_pop   (can_pop),
      .overrun   (w_fifo_ovr)
   );

   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Brief    : Self-checking bench: 8N1 default receiver and a 7E2 receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int BAUD  = 115200;
   localparam int CLK_A = 50_000_000;
   localparam int CLK_B = 3_686_400;
   localparam int BIT_A = 16 * ((CLK_A + 8 * BAUD) / (16 * BAUD));
   localparam int BIT_B = 16 * ((CLK_B + 8 * BAUD) / (16 * BAUD));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              rx_a, rx_b;
   logic [2:0]        pop_a, pop_b;
   logic              clr_a, clr_b;
   logic [N-1:0][7:0] data_a, data_b;
   logic [2:0]        can_a, can_b;
   logic              perr_a, ferr_a, ovr_a;
   logic              perr_b, ferr_b, ovr_b;

   uart_rx_cfg #(.CLK_FREQ(CLK_A), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .DEPTH(DEPTH), .N(N)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .can_pop(can_a), .pop(pop_a),
      .err_clr(clr_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a));

   uart_rx_cfg #(.CLK_FREQ(CLK_B), .BAUDRATE(BAUD), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .DEPTH(DEPTH), .N(N)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .can_pop(can_b), .pop(pop_b),
      .err_clr(clr_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string             name;
      int                nsend;
      logic [4:0][7:0]   tx;
      logic [2:0]        pop;
      logic [2:0]        exp_can;
      logic [3:0][7:0]   exp_data;
      logic              exp_ovr;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit sel_b, input logic v, input int clks);
      if (sel_b) rx_b = v;
      else       rx_a = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send(input bit sel_b, input logic [15:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) drive(sel_b, f[i], sel_b ? BIT_B : BIT_A);
   endtask

   task automatic pulse_pop(input bit sel_b, input logic [2:0] p);
      if (sel_b) pop_b = p; else pop_a = p;
      @(negedge clk);
      pop_a = '0; pop_b = '0;
      @(negedge clk);
   endtask

   task automatic pulse_clr(input bit sel_b);
      if (sel_b) clr_b = 1'b1; else clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0; clr_b = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [15:0] frame_8n1(input logic [7:0] b);
      logic [15:0] f;
      f       = '1;
      f[0]    = 1'b0;
      f[8:1]  = b;
      return f;
   endfunction

   // 7 data bits, even parity, two stop bits (stops[0] first on the line).
   function automatic logic [15:0] frame_7e2(input logic [6:0] d, input bit flip,
                                             input logic [1:0] stops);
      logic [15:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[7:1] = d;
      f[8]   = (($countones(d) % 2) == 1) ^ flip;
      f[9]   = stops[0];
      f[10]  = stops[1];
      return f;
   endfunction

   task automatic check_a(input string tag, input logic [2:0] ecan, input logic [7:0] d0,
                          input logic ep, input logic ef, input logic eo);
      check({tag, ".can_pop"},    32'(can_a),     32'(ecan));
      check({tag, ".data0"},      32'(data_a[0]), 32'(d0));
      check({tag, ".parity_err"}, 32'(perr_a),    32'(ep));
      check({tag, ".frame_err"},  32'(ferr_a),    32'(ef));
      check({tag, ".overrun"},    32'(ovr_a),     32'(eo));
   endtask

   // Reference model for dut_b: queue of stored bytes plus sticky flags.
   logic [7:0] q[$];
   bit exp_perr, exp_ferr, exp_ovr;

   task automatic check_b_model(input string tag);
      int ecan;
      ecan = (q.size() > N) ? N : q.size();
      check({tag, ".can_pop"}, 32'(can_b), 32'(ecan));
      for (int i = 0; i < N; i++)
         check($sformatf("%s.lane%0d", tag, i), 32'(data_b[i]), (i < ecan) ? 32'(q[i]) : 32'd0);
      check({tag, ".parity_err"}, 32'(perr_b), 32'(exp_perr));
      check({tag, ".frame_err"},  32'(ferr_b), 32'(exp_ferr));
      check({tag, ".overrun"},    32'(ovr_b),  32'(exp_ovr));
   endtask

   initial begin
      logic [15:0] f;
      logic [6:0]  d;
      logic [1:0]  stops;
      bit          flip;
      int          r, p, eff;

      rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
      pop_a = '0; pop_b = '0; clr_a = 1'b0; clr_b = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_a("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("reset.data_all", 32'(data_a), 32'd0);
      check("reset.b_can_pop", 32'(can_b), 32'd0);

      // 7E2: good 0x35, then 0x35 with the parity bit inverted.
      send(1'b1, frame_7e2(7'h35, 1'b0, 2'b11), 11);
      send(1'b1, frame_7e2(7'h35, 1'b1, 2'b11), 11);
      drive(1'b1, 1'b1, BIT_B);
      check("par.can_pop", 32'(can_b), 32'd1);
      check("par.data0", 32'(data_b[0]), 32'h35);
      check("par.parity_err", 32'(perr_b), 32'd1);
      check("par.frame_err", 32'(ferr_b), 32'd0);
      pulse_clr(1'b1);
      check("par.cleared", 32'(perr_b), 32'd0);
      pulse_pop(1'b1, 3'd1);
      check("par.empty", 32'(can_b), 32'd0);

      // Randomised 7E2 traffic against the queue model.
      q.delete(); exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
      for (int fr = 0; fr < 30; fr++) begin
         d = 7'($urandom_range(0, 127));
         r = $urandom_range(0, 7);
         flip  = (r == 0) || (r == 1);
         stops = (r == 2) ? 2'b10 : (r == 3) ? 2'b01 : 2'b11;
         send(1'b1, frame_7e2(d, flip, stops), 11);
         drive(1'b1, 1'b1, BIT_B + $urandom_range(0, BIT_B));
         if (stops != 2'b11)      exp_ferr = 1;
         else if (flip)           exp_perr = 1;
         else if (q.size() < DEPTH) q.push_back({1'b0, d});
         else                     exp_ovr = 1;
         check_b_model($sformatf("rnd%0d", fr));
         if ($urandom_range(0, 2) == 0) begin
            p   = $urandom_range(0, 4);
            eff = (p < q.size()) ? p : q.size();
            if (eff > N) eff = N;
            pulse_pop(1'b1, 3'(p));
            for (int k = 0; k < eff; k++) void'(q.pop_front());
         end
         if ($urandom_range(0, 4) == 0) begin
            pulse_clr(1'b1);
            exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
         end
      end
      check_b_model("rnd_end");

      // Default 8N1 receiver: fill, saturating pop, overrun, partial pop.
      vecs[0] = '{"fill3",  3, {8'h00, 8'h00, 8'hF0, 8'hF0, 8'h55}, 3'd0, 3'd3,
                  {8'h00, 8'hF0, 8'hF0, 8'h55}, 1'b0};
      vecs[1] = '{"popsat", 0, 40'h0, 3'd4, 3'd0, 32'h0, 1'b0};
      vecs[2] = '{"ovr5",   5, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 3'd0, 3'd4,
                  {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1};
      vecs[3] = '{"pop2",   0, 40'h0, 3'd2, 3'd2, {8'h00, 8'h00, 8'h04, 8'h03}, 1'b1};
      for (int v = 0; v < 4; v++) begin
         for (int b = 0; b < vecs[v].nsend; b++) send(1'b0, frame_8n1(vecs[v].tx[b]), 10);
         if (vecs[v].pop != 0) pulse_pop(1'b0, vecs[v].pop);
         check({vecs[v].name, ".can_pop"}, 32'(can_a), 32'(vecs[v].exp_can));
         for (int i = 0; i < N; i++)
            check($sformatf("%s.lane%0d", vecs[v].name, i), 32'(data_a[i]),
                  32'(vecs[v].exp_data[i]));
         check({vecs[v].name, ".overrun"}, 32'(ovr_a), 32'(vecs[v].exp_ovr));
         check({vecs[v].name, ".perr"}, 32'(perr_a), 32'd0);
         check({vecs[v].name, ".ferr"}, 32'(ferr_a), 32'd0);
      end
      pulse_clr(1'b0);
      pulse_pop(1'b0, 3'd2);
      check_a("drain", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Line held low through the stop bit and beyond: framing error.
      drive(1'b0, 1'b0, 13 * BIT_A);
      drive(1'b0, 1'b1, BIT_A);
      check_a("break", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      send(1'b0, frame_8n1(8'hA5), 10);
      check_a("after_break", 3'd1, 8'hA5, 1'b0, 1'b1, 1'b0);
      pulse_pop(1'b0, 3'd1);
      pulse_clr(1'b0);
      check_a("break_clr", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Short low glitch on an idle line, then one corrupted middle sample.
      drive(1'b0, 1'b0, 4);
      drive(1'b0, 1'b1, 2 * BIT_A);
      check_a("glitch", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      f = frame_8n1(8'h55);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            drive(1'b0, 1'b1, 236);
            drive(1'b0, 1'b0, 14);
            drive(1'b0, 1'b1, BIT_A - 250);
         end else begin
            drive(1'b0, f[i], BIT_A);
         end
      end
      check_a("vote", 3'd1, 8'h55, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a data bit aborts the frame.
      f = frame_8n1(8'h96);
      for (int i = 0; i < 4; i++) drive(1'b0, f[i], BIT_A);
      drive(1'b0, f[4], BIT_A / 2);
      rst = 1'b1; rx_a = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_a("midrst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 2 * BIT_A);
      send(1'b0, frame_8n1(8'h3C), 10);
      check_a("post_rst", 3'd1, 8'h3C, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
